wb_arbiter_2m: RTL

Two-master Wishbone (classic, single-cycle-handshake) bus arbiter that shares the SoC peripheral/memory bus between the RV32I core's data port (master 0) and a secondary master such as a debug/DMA/boot-load port (master 1). It sits between the two masters and the existing bus interconnect. It grants ownership round-robin and holds a grant for the full `cyc` cycle of the owner. An optional watchdog terminates hung slave accesses with a bus error.

---
 rtl/wb_arbiter_2m.sv | 101 ++++++++++
 1 files changed

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: round-robin two-master Wishbone classic arbiter; define WB_ARB_TIMEOUT_EN to add the stall watchdog
module wb_arbiter_2m #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 255,
  localparam int SEL_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  input  logic [SEL_W-1:0]  m0_sel_i,
  output logic [DATA_W-1:0] m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  input  logic [SEL_W-1:0]  m1_sel_i,
  output logic [DATA_W-1:0] m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_adr_o,
  output logic [DATA_W-1:0] s_dat_o,
  output logic [SEL_W-1:0]  s_sel_o,
  input  logic [DATA_W-1:0] s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  output logic [1:0]        grant_o,
  output logic              timeout_o
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, own0, own1, stb_raw, abort;
  assign own0 = state_q == OWN0;
  assign own1 = state_q == OWN1;
  // pick the next owner: lone requester wins, a tie goes to the master not granted last; owner keeps the bus for its whole cyc
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    case (state_q)
      IDLE:
        if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
          state_d = OWN0;
          last_d = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = OWN1;
          last_d = 1'b1;
        end
      OWN0: state_d = m0_cyc_i ? OWN0 : IDLE;
      OWN1: state_d = m1_cyc_i ? OWN1 : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // owner register; last starts at 1 so master 0 wins the first tie
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
    end
  end
  assign stb_raw   = (own0 & m0_stb_i) | (own1 & m1_stb_i);
  assign s_cyc_o   = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
  assign s_stb_o   = stb_raw & ~abort;
  assign s_we_o    = (own0 & m0_we_i) | (own1 & m1_we_i);
  assign s_adr_o   = own0 ? m0_adr_i : own1 ? m1_adr_i : '0;
  assign s_dat_o   = own0 ? m0_dat_i : own1 ? m1_dat_i : '0;
  assign s_sel_o   = own0 ? m0_sel_i : own1 ? m1_sel_i : '0;
  assign m0_dat_o  = s_dat_i;
  assign m1_dat_o  = s_dat_i;
  assign m0_ack_o  = own0 & s_ack_i;
  assign m1_ack_o  = own1 & s_ack_i;
  assign m0_err_o  = own0 & (s_err_i | abort);
  assign m1_err_o  = own1 & (s_err_i | abort);
  assign grant_o   = {own1, own0};
  assign timeout_o = abort;
`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  assign abort = stb_raw && cnt_q == 16'(TIMEOUT);
  // count stalled strobe cycles; a response, a dropped strobe or the abort itself restarts the count
  always_comb cnt_d = (!stb_raw || s_ack_i || s_err_i || abort) ? 16'd0 : cnt_q + 16'd1;
  // watchdog counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= 16'd0;
    else cnt_q <= cnt_d;
  end
`else
  assign abort = stb_raw && (TIMEOUT < 0);
`endif
endmodule
